sobel_acc_param: RTL and testbench
==================================

// Module: sobel_acc_param
// PURPOSE
//  Parametrised Sobel edge-detection accelerator, the successor of the fixed 352x288 task-2 accelerator.
//  Streams an 8-bit greyscale image from word memory, computes per-pixel Sobel magnitude (or thresholded
//  binary edge map), writes the result image back. Sits between the start/finish controller and the
//  shared 32-bit data memory; arbitrary image size and base addresses, new threshold mode.
// PARAMETERS
//  IMG_W     352                 image width in pixels; multiple of 4, >= 8
//  IMG_H     288                 image height in pixels; >= 3
//  ADDR_W    16                  word-address width
//  SRC_BASE  0                   word address of source pixel 0
//  DST_BASE  IMG_W*IMG_H/4       word address of result pixel 0 (25344 at defaults)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       asynchronous, active-low reset
//  addr       out  ADDR_W  word address
//  dataR      in   32      read data, valid the cycle after a read request
//  dataW      out  32      write data, valid while en=1,we=1
//  en         out  1       memory request
//  we         out  1       1=write, 0=read (meaningful only with en=1)
//  start      in   1       level; begin a run when sampled high in IDLE
//  finish     out  1       high in DONE
//  busy       out  1       high from leaving IDLE until entering DONE
//  mode       in   1       0=magnitude, 1=threshold; sampled with start
//  threshold  in   8       threshold level; sampled with start
// BEHAVIOUR
//  - reset low: state=IDLE; addr=0, dataW=0, en=0, we=0, finish=0, busy=0, window/counters cleared.
//    Reset mid-run aborts immediately; no further memory request is issued.
//  - Pixel packing: pixel 4c+i of a row in word bits [8i+7:8i]; WW=IMG_W/4 words per row.
//    Source word (r,c) at SRC_BASE+r*WW+c, result word at DST_BASE+r*WW+c.
//  - States: IDLE -> (start) RUN -> DONE -> (start low) IDLE. start while RUN/DONE ignored.
//  - RUN walks rows r=0..IMG_H-1, words c=0..WW-1 in order; one memory access per cycle.
//    * Border rows (r=0, r=IMG_H-1): one write cycle per word, dataW=0, no reads.
//    * Interior rows: 3 prime reads (rows r-1,r,r+1 of word 0); then per word c: if c<WW-1
//      3 reads of word c+1 (rows r-1,r,r+1), then 1 write of word c. Window = 3 rows x 3 words;
//      off-image words (c-1<0, c+1>=WW) read as zero.
//    * Interior row cycles = 3 + 4*(WW-1) + 1; border row cycles = WW.
//    * Read issued in cycle t: dataR sampled at end of t+1. The write of word c is the cycle right
//      after its last read; it uses the registered window plus the dataR arriving that cycle.
//  - Pixel (r,x) result: 0 if x=0 or x=IMG_W-1 (and whole border rows). Else with 3x3 window p:
//    Dx=(p13+2p23+p33)-(p11+2p21+p31), Dy=(p31+2p32+p33)-(p11+2p12+p13), signed 11-bit;
//    mag=|Dx|+|Dy|, saturated to 255. mode=0: out=mag; mode=1: out = mag>=threshold ? 255 : 0.
//  - After the final write (r=IMG_H-1, c=WW-1): en=0, we=0, finish=1, busy=0 (DONE).
//  - DONE holds finish=1 until start is sampled low, then IDLE with finish=0 next cycle.
//  - en=0 in IDLE/DONE; addr/dataW hold last value outside requests.
//  - Run totals: 2*WW + (IMG_H-2)*(4*WW) cycles of busy; every result word written exactly once.
// TESTING
//  1 IMG_W=8,IMG_H=4, flat image 0x40 -> 8 result words all 0x00000000, busy exactly 20 cycles.
//  2 IMG_W=8,IMG_H=4, col x<4 =0, x>=4 =0xFF, mode=0 -> interior rows word0=0xFF000000,
//    word1=0x000000FF, borders 0.
//  3 Same image, mode=1, threshold=0x80 -> same pattern; threshold=0x00 -> interior non-border
//    pixels 0xFF, border pixels 0.
//  4 Single bright pixel 0xFF at (2,3) of 8x5 -> neighbours saturate at 0xFF, others 0; check DST_BASE
//    offset and little-endian packing.
//  5 Reset low mid-run (row 2) -> en=0,busy=0 immediately; restart with start -> full correct image.
//  6 Defaults 352x288 random image vs bench golden model -> 25344 matching words, finish held until
//    start low.

Source files
------------

// File: rtl/sobel_acc_param_if.sv
`default_nettype none
// ============================================================================
// Module      : sobel_acc_param_if
// Description : Memory bus plus start/finish control bundle for the Sobel
//               accelerator.
// Revision    : 1.0 - initial release
// ============================================================================
interface sobel_acc_param_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic [31:0]       dataR;
  logic [31:0]       dataW;
  logic              en;
  logic              we;
  logic              start;
  logic              finish;
  logic              busy;
  logic              mode;
  logic [7:0]        threshold;

  modport master (
    output addr, dataW, en, we, finish, busy,
    input  dataR, start, mode, threshold
  );

  modport slave (
    input  addr, dataW, en, we, finish, busy,
    output dataR, start, mode, threshold
  );
endinterface
`default_nettype wire

// File: rtl/sobel_acc_param.sv
`default_nettype none
// ============================================================================
// Module      : sobel_acc_param
// Description : Streaming Sobel magnitude / threshold accelerator over a
//               32-bit word memory holding a packed 8-bit greyscale image.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_acc_param #(
  parameter int IMG_W    = 352,
  parameter int IMG_H    = 288,
  parameter int ADDR_W   = 16,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = IMG_W*IMG_H/4
) (
  input wire                clk,
  input wire                reset,
  sobel_acc_param_if.master bus
);
  localparam int c_ww    = IMG_W/4;
  localparam int c_col_w = (c_ww > 1) ? $clog2(c_ww) : 1;
  localparam int c_row_w = $clog2(IMG_H);
  localparam logic [c_col_w-1:0] c_last_col = c_col_w'(c_ww-1);
  localparam logic [c_row_w-1:0] c_last_row = c_row_w'(IMG_H-1);
  localparam logic [c_col_w-1:0] c_col_one  = c_col_w'(1);
  localparam logic [c_row_w-1:0] c_row_one  = c_row_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [c_row_w-1:0]   row_q, row_d;
  logic [c_col_w-1:0]   col_q, col_d;
  logic [1:0]           phase_q, phase_d;
  logic                 prime_q, prime_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [1:0]           rd_row_q, rd_row_d;
  logic                 mode_q, mode_d;
  logic [7:0]           thr_q, thr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [31:0]          dataw_q, dataw_d;
  // Window: left keeps only the byte adjacent to the current word, cur is
  // the word being computed, nxt holds rows r-1/r of word c+1 (row r+1 of
  // word c+1 is taken straight from dataR on the write cycle).
  logic [2:0][7:0]      left_q, left_d;
  logic [2:0][31:0]     cur_q, cur_d;
  logic [1:0][31:0]     nxt_q, nxt_d;

  logic                 w_run, w_border, w_last_col, w_write;
  logic [c_row_w-1:0]   w_row_inc;
  logic [c_col_w-1:0]   w_col_inc;
  logic [ADDR_W-1:0]    w_rd_row, w_rd_col, w_rd_addr, w_wr_addr;
  logic [2:0][47:0]     w_rowv;
  logic [31:0]          w_result;
  logic                 w_en, w_we;
  logic [ADDR_W-1:0]    w_addr;
  logic [31:0]          w_dataw;

  assign w_run      = (state_q == S_RUN);
  assign w_border   = (row_q == '0) || (row_q == c_last_row);
  assign w_last_col = (col_q == c_last_col);
  assign w_write    = w_border || (!prime_q && (phase_q == 2'd3));
  assign w_row_inc  = row_q + c_row_one;
  assign w_col_inc  = col_q + c_col_one;

  assign w_rd_row  = ADDR_W'(row_q) + ADDR_W'(phase_q) - ADDR_W'(1);
  assign w_rd_col  = prime_q ? '0 : (ADDR_W'(col_q) + ADDR_W'(1));
  assign w_rd_addr = ADDR_W'(SRC_BASE) + w_rd_row * ADDR_W'(c_ww) + w_rd_col;
  assign w_wr_addr = ADDR_W'(DST_BASE) + ADDR_W'(row_q) * ADDR_W'(c_ww) + ADDR_W'(col_q);

  // 48-bit row strip: neighbour byte | current word | neighbour byte.
  assign w_rowv[0] = {(w_last_col ? 8'h00 : nxt_q[0][7:0]),   cur_q[0], left_q[0]};
  assign w_rowv[1] = {(w_last_col ? 8'h00 : nxt_q[1][7:0]),   cur_q[1], left_q[1]};
  assign w_rowv[2] = {(w_last_col ? 8'h00 : bus.dataR[7:0]),  cur_q[2], left_q[2]};

  for (genvar i = 0; i < 4; i++) begin : g_px
    logic [7:0]        l0, l1, l2, m0, m2, r0, r1, r2;
    logic [9:0]        sum_l, sum_r, sum_t, sum_b;
    logic signed [10:0] dx, dy;
    logic [10:0]       ax, ay;
    logic [11:0]       mag;
    logic [7:0]        sat;
    logic              edge_px;

    assign l0 = w_rowv[0][8*i +: 8];
    assign l1 = w_rowv[1][8*i +: 8];
    assign l2 = w_rowv[2][8*i +: 8];
    assign m0 = w_rowv[0][8*i+8 +: 8];
    assign m2 = w_rowv[2][8*i+8 +: 8];
    assign r0 = w_rowv[0][8*i+16 +: 8];
    assign r1 = w_rowv[1][8*i+16 +: 8];
    assign r2 = w_rowv[2][8*i+16 +: 8];

    assign sum_r = {2'b00, r0} + {1'b0, r1, 1'b0} + {2'b00, r2};
    assign sum_l = {2'b00, l0} + {1'b0, l1, 1'b0} + {2'b00, l2};
    assign sum_b = {2'b00, l2} + {1'b0, m2, 1'b0} + {2'b00, r2};
    assign sum_t = {2'b00, l0} + {1'b0, m0, 1'b0} + {2'b00, r0};

    assign dx  = $signed({1'b0, sum_r}) - $signed({1'b0, sum_l});
    assign dy  = $signed({1'b0, sum_b}) - $signed({1'b0, sum_t});
    assign ax  = dx[10] ? 11'(-dx) : 11'(dx);
    assign ay  = dy[10] ? 11'(-dy) : 11'(dy);
    assign mag = {1'b0, ax} + {1'b0, ay};
    assign sat = (mag > 12'd255) ? 8'hFF : mag[7:0];

    assign edge_px = ((i == 0) && (col_q == '0)) || ((i == 3) && w_last_col);
    assign w_result[8*i +: 8] = (w_border || edge_px) ? 8'h00 :
                                mode_q ? ((sat >= thr_q) ? 8'hFF : 8'h00) : sat;
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    phase_d   = phase_q;
    prime_d   = prime_q;
    rd_pend_d = 1'b0;
    rd_row_d  = rd_row_q;
    mode_d    = mode_q;
    thr_d     = thr_q;
    left_d    = left_q;
    cur_d     = cur_q;
    nxt_d     = nxt_q;
    w_en      = 1'b0;
    w_we      = 1'b0;
    w_addr    = addr_q;
    w_dataw   = dataw_q;

    // Arrival of the row r+1 word completes a column: slide the window.
    if (rd_pend_q) begin
      if (rd_row_q == 2'd2) begin
        for (int j = 0; j < 3; j++) left_d[j] = cur_q[j][31:24];
        cur_d = {bus.dataR, nxt_q[1], nxt_q[0]};
      end else begin
        nxt_d[rd_row_q[0]] = bus.dataR;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          row_d   = '0;
          col_d   = '0;
          phase_d = 2'd0;
          prime_d = 1'b0;
          mode_d  = bus.mode;
          thr_d   = bus.threshold;
        end
      end
      S_RUN: begin
        w_en = 1'b1;
        if (w_write) begin
          w_we    = 1'b1;
          w_addr  = w_wr_addr;
          w_dataw = w_result;
          if (w_last_col) begin
            col_d   = '0;
            phase_d = 2'd0;
            if (row_q == c_last_row) begin
              state_d = S_DONE;
            end else begin
              row_d   = w_row_inc;
              prime_d = (w_row_inc != c_last_row);
            end
          end else begin
            col_d   = w_col_inc;
            phase_d = (w_border || (w_col_inc != c_last_col)) ? 2'd0 : 2'd3;
          end
        end else begin
          w_addr    = w_rd_addr;
          rd_pend_d = 1'b1;
          rd_row_d  = phase_q;
          if (prime_q && (phase_q == 2'd0)) begin
            left_d = '0;
            cur_d  = '0;
            nxt_d  = '0;
          end
          if (prime_q && (phase_q == 2'd2)) begin
            prime_d = 1'b0;
            phase_d = 2'd0;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        if (!bus.start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    addr_d  = w_addr;
    dataw_d = w_dataw;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      phase_q   <= 2'd0;
      prime_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_row_q  <= 2'd0;
      mode_q    <= 1'b0;
      thr_q     <= 8'h00;
      addr_q    <= '0;
      dataw_q   <= 32'h0;
      left_q    <= '0;
      cur_q     <= '0;
      nxt_q     <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      phase_q   <= phase_d;
      prime_q   <= prime_d;
      rd_pend_q <= rd_pend_d;
      rd_row_q  <= rd_row_d;
      mode_q    <= mode_d;
      thr_q     <= thr_d;
      addr_q    <= addr_d;
      dataw_q   <= dataw_d;
      left_q    <= left_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
    end
  end

  assign bus.addr   = w_addr;
  assign bus.dataW  = w_dataw;
  assign bus.en     = w_en;
  assign bus.we     = w_we;
  assign bus.busy   = w_run;
  assign bus.finish = (state_q == S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_sobel_acc_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_acc_param
// Description : Self-checking bench for sobel_acc_param (16x6 image, offset
//               source/result bases) against a plain-arithmetic Sobel model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_acc_param;
  localparam int W   = 16;
  localparam int H   = 6;
  localparam int AW  = 8;
  localparam int SB  = 5;
  localparam int DB  = 40;
  localparam int WW  = W/4;
  localparam int NW  = WW*H;
  localparam int BUSY_EXP = 2*WW + (H-2)*4*WW;

  logic clk;
  logic reset;
  logic clr;

  sobel_acc_param_if #(.ADDR_W(AW)) bus();

  sobel_acc_param #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .SRC_BASE(SB), .DST_BASE(DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] src_mem [NW];
  logic [31:0] dst_mem [NW];
  int          wr_cnt  [NW];
  int          stray;
  int          busy_cyc;
  int          n_cmp;
  int          n_err;

  // Synchronous word memory: read data appears the cycle after the request.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NW; i++) begin
        dst_mem[i] <= 32'hDEADBEEF;
        wr_cnt[i]  <= 0;
      end
      stray     <= 0;
      busy_cyc  <= 0;
      bus.dataR <= 32'h0;
    end else begin
      bus.dataR <= $urandom;
      if (bus.busy) busy_cyc <= busy_cyc + 1;
      if (bus.en && bus.we) begin
        if (int'(bus.addr) >= DB && int'(bus.addr) < DB + NW) begin
          dst_mem[int'(bus.addr) - DB] <= bus.dataW;
          wr_cnt[int'(bus.addr) - DB]  <= wr_cnt[int'(bus.addr) - DB] + 1;
        end else begin
          stray <= stray + 1;
        end
      end else if (bus.en) begin
        if (int'(bus.addr) >= SB && int'(bus.addr) < SB + NW)
          bus.dataR <= src_mem[int'(bus.addr) - SB];
        else
          stray <= stray + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic int pix(input int r, input int x);
    logic [31:0] w;
    if (r < 0 || r >= H || x < 0 || x >= W) return 0;
    w = src_mem[r*WW + x/4];
    return int'(w[8*(x%4) +: 8]);
  endfunction

  function automatic logic [31:0] model_word(input int r, input int c, input bit md, input int thr);
    logic [31:0] w;
    int x, dx, dy, mag, v;
    w = 32'h0;
    for (int i = 0; i < 4; i++) begin
      x = 4*c + i;
      v = 0;
      if (!(r == 0 || r == H-1 || x == 0 || x == W-1)) begin
        dx = (pix(r-1,x+1) + 2*pix(r,x+1) + pix(r+1,x+1))
           - (pix(r-1,x-1) + 2*pix(r,x-1) + pix(r+1,x-1));
        dy = (pix(r+1,x-1) + 2*pix(r+1,x) + pix(r+1,x+1))
           - (pix(r-1,x-1) + 2*pix(r-1,x) + pix(r-1,x+1));
        mag = (dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy);
        if (mag > 255) mag = 255;
        v = md ? ((mag >= thr) ? 255 : 0) : mag;
      end
      w[8*i +: 8] = 8'(v);
    end
    return w;
  endfunction

  task automatic fill(input int kind);
    logic [7:0] v;
    for (int r = 0; r < H; r++) begin
      for (int x = 0; x < W; x++) begin
        case (kind)
          0:       v = 8'h40;
          1:       v = (x < 8) ? 8'h00 : 8'hFF;
          2:       v = (r == 2 && x == 3) ? 8'hFF : 8'h00;
          3:       v = 8'($urandom);
          default: v = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
        endcase
        src_mem[r*WW + x/4][8*(x%4) +: 8] = v;
      end
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic run_img(input bit md, input logic [7:0] thr, input string tag);
    pulse_clr();
    bus.mode      = md;
    bus.threshold = thr;
    bus.start     = 1'b1;
    @(negedge clk);
    chk({tag, " busy after start"}, 32'(bus.busy), 32'd1);
    // Inputs are latched at start; disturb them for the rest of the run.
    bus.mode      = ~md;
    bus.threshold = ~thr;
    for (int k = 0; k < 4*BUSY_EXP; k++) begin
      if (bus.finish) break;
      @(negedge clk);
    end
    chk({tag, " finish"}, 32'(bus.finish), 32'd1);
    chk({tag, " busy in done"}, 32'(bus.busy), 32'd0);
    chk({tag, " en in done"}, 32'(bus.en), 32'd0);
    chk({tag, " busy cycles"}, 32'(busy_cyc), 32'(BUSY_EXP));
    repeat (3) @(negedge clk);
    chk({tag, " finish held"}, 32'(bus.finish), 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, " finish cleared"}, 32'(bus.finish), 32'd0);
    chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < WW; c++) begin
        chk($sformatf("%s word r%0d c%0d", tag, r, c), dst_mem[r*WW+c],
            model_word(r, c, md, int'(thr)));
        chk($sformatf("%s wrcnt r%0d c%0d", tag, r, c), 32'(wr_cnt[r*WW+c]), 32'd1);
      end
    end
    chk({tag, " stray accesses"}, 32'(stray), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    clr           = 1'b0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.mode      = 1'b0;
    bus.threshold = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset en", 32'(bus.en), 32'd0);
    chk("reset we", 32'(bus.we), 32'd0);
    chk("reset addr", 32'(bus.addr), 32'd0);
    chk("reset dataW", bus.dataW, 32'd0);
    chk("reset finish", 32'(bus.finish), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle without start", 32'(bus.busy), 32'd0);

    fill(0);
    run_img(1'b0, 8'h00, "flat");
    chk("flat interior word", dst_mem[2*WW+1], 32'h0);

    fill(1);
    run_img(1'b0, 8'h00, "vedge mag");
    chk("vedge mag w1", dst_mem[2*WW+1], 32'hFF000000);
    chk("vedge mag w2", dst_mem[2*WW+2], 32'h000000FF);
    run_img(1'b1, 8'h80, "vedge thr80");
    chk("vedge thr80 w1", dst_mem[3*WW+1], 32'hFF000000);
    chk("vedge thr80 w2", dst_mem[3*WW+2], 32'h000000FF);
    run_img(1'b1, 8'h00, "vedge thr0");
    chk("vedge thr0 w0", dst_mem[WW+0], 32'hFFFFFF00);
    chk("vedge thr0 w3", dst_mem[WW+3], 32'h00FFFFFF);
    chk("vedge thr0 border", dst_mem[0], 32'h0);

    fill(2);
    run_img(1'b0, 8'h00, "dot");
    chk("dot r1 w0", dst_mem[1*WW+0], 32'hFFFF0000);
    chk("dot r2 w0", dst_mem[2*WW+0], 32'h00FF0000);
    chk("dot r3 w1", dst_mem[3*WW+1], 32'h000000FF);
    chk("dot r2 w2", dst_mem[2*WW+2], 32'h0);

    // Abort in the middle of row 2, then a full clean run.
    fill(3);
    pulse_clr();
    bus.start = 1'b1;
    repeat (23) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort en", 32'(bus.en), 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort finish", 32'(bus.finish), 32'd0);
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("abort hold en %0d", k), 32'(bus.en), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("after abort idle", 32'(bus.busy), 32'd0);
    run_img(1'b0, 8'h00, "restart");

    for (int t = 0; t < 3; t++) begin
      fill(3);
      run_img(1'($urandom_range(0, 1)), 8'($urandom), $sformatf("rand%0d", t));
    end
    fill(4);
    run_img(1'b1, 8'($urandom_range(1, 254)), "sat thr");
    fill(4);
    run_img(1'b0, 8'h00, "sat mag");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
